// File: rtl/store_buffer_pkg.sv
// Shared types and sizing helpers for the store buffer.
//   sb_state_t      : RUN accepts stores; DRAIN blocks stores until the queue empties.
//   data_byte_size  : bytes per store data word.
//   idx_width       : bits needed to index a byte inside the data word.
package store_buffer_pkg;

  typedef enum logic {SB_RUN, SB_DRAIN} sb_state_t;

  function automatic int unsigned data_byte_size(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned idx_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/byte_range_overlap.sv
// Checks whether two byte ranges [addr_a, addr_a+n_a) and [addr_b, addr_b+n_b) intersect.
//   addr_a, n_a : first range start and length in bytes
//   addr_b, n_b : second range start and length in bytes
//   hit         : ranges share at least one byte; an empty range never hits
// End addresses carry one extra bit so a range touching the top of the address space
// does not wrap around and alias with low addresses.
module byte_range_overlap #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned N_WIDTH    = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [N_WIDTH-1:0]    n_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [N_WIDTH-1:0]    n_b,
  output logic                  hit
);

  logic [ADDR_WIDTH:0] start_a;
  logic [ADDR_WIDTH:0] start_b;
  logic [ADDR_WIDTH:0] end_a;
  logic [ADDR_WIDTH:0] end_b;

  always_comb begin
    start_a = {1'b0, addr_a};
    start_b = {1'b0, addr_b};
    end_a   = start_a + (ADDR_WIDTH + 1)'(n_a);
    end_b   = start_b + (ADDR_WIDTH + 1)'(n_b);
    hit     = (n_a != '0) && (n_b != '0) && (start_a < end_b) && (start_b < end_a);
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write queue between the CPU store path and the memory write port.
//   clk, rst               : clock, synchronous active-high reset
//   st_valid/st_ready      : store handshake; st_addr/st_data/st_bytes describe the store
//   ld_addr/ld_bytes       : load range to check; ld_hazard flags overlap with a buffered store
//   flush_req/flush_done   : fence drain request and single-cycle completion pulse
//   empty                  : no buffered stores
//   mem_write_*            : head entry presented to memory; mem_write_done commits it at the
//                            next clock edge
// Stores are kept in a circular FIFO and drained strictly in order. A zero-byte store completes
// its handshake but is not queued; oversized stores are clamped to a full data word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned IDX_W     = idx_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [IDX_W:0]        st_bytes,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [IDX_W:0]        ld_bytes,
  output logic                  ld_hazard,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  empty,
  output logic                  mem_write_activate,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [IDX_W:0]        mem_bytes_to_write,
  input  logic                  mem_write_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W:0]   MAX_BYTES = (IDX_W + 1)'(data_byte_size(DATA_WIDTH));
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_W:0]        bytes;
  } store_entry_t;

  store_entry_t     entries_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  sb_state_t        state_q;

  logic             cnt_empty;
  logic             push_hs;
  logic             push;
  logic             pop;
  logic [IDX_W:0]   st_bytes_sat;
  store_entry_t     head_entry;

  always_comb begin
    cnt_empty    = (count_q == '0);
    st_bytes_sat = (st_bytes > MAX_BYTES) ? MAX_BYTES : st_bytes;
    // No full-bypass: a pop in the same cycle does not open a slot for a push.
    st_ready     = !rst && (state_q == SB_RUN) && (count_q != FULL_CNT);
    push_hs      = st_valid && st_ready;
    push         = push_hs && (st_bytes != '0);
    // Outputs are forced to their idle values while reset is held, so a write_done
    // arriving during reset can never pop or commit anything.
    empty              = rst || cnt_empty;
    mem_write_activate = !empty;
    pop                = mem_write_done && mem_write_activate;
    head_entry         = mem_write_activate ? entries_q[head_q] : '0;
    mem_write_addr     = head_entry.addr;
    mem_write_data     = head_entry.data;
    mem_bytes_to_write = head_entry.bytes;
    flush_done         = !rst && (state_q == SB_DRAIN) && cnt_empty;
  end

  // Load hazard: every slot between head and head+count is live. The entry being popped this
  // cycle still counts because memory only commits it at the coming edge.
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(i) - head_q;
    assign entry_valid[i] = CNT_W'(offset) < count_q;

    byte_range_overlap #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .N_WIDTH    (IDX_W + 1)
    ) u_overlap (
      .addr_a (entries_q[i].addr),
      .n_a    (entries_q[i].bytes),
      .addr_b (ld_addr),
      .n_b    (ld_bytes),
      .hit    (entry_hit[i])
    );
  end

  assign ld_hazard = !rst && |(entry_valid & entry_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= SB_RUN;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      if (push) begin
        entries_q[tail_q] <= '{addr: st_addr, data: st_data, bytes: st_bytes_sat};
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // flush_req while already draining is ignored; DRAIN exits the cycle after empty.
      case (state_q)
        SB_RUN:   if (flush_req) state_q <= SB_DRAIN;
        SB_DRAIN: if (cnt_empty) state_q <= SB_RUN;
        default:  state_q <= SB_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] bytes;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [BW-1:0] st_bytes = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [BW-1:0] ld_bytes = '0;
  logic          ld_hazard;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          empty;
  logic          mem_write_activate;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic [BW-1:0] mem_bytes_to_write;
  logic          mem_write_done;

  logic mem_auto_en = 1'b0;
  logic mem_done_auto = 1'b0;
  logic mem_done_force = 1'b0;
  assign mem_write_done = mem_auto_en ? mem_done_auto : mem_done_force;

  int checks = 0;
  int failures = 0;

  ent_t exp_q[$];
  ent_t commit_q[$];
  ent_t ce;
  logic [7:0] mem_bytes [longint unsigned];
  int act_run = 0;

  always #5 clk = ~clk;

  store_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .st_valid           (st_valid),
    .st_ready           (st_ready),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .st_bytes           (st_bytes),
    .ld_addr            (ld_addr),
    .ld_bytes           (ld_bytes),
    .ld_hazard          (ld_hazard),
    .flush_req          (flush_req),
    .flush_done         (flush_done),
    .empty              (empty),
    .mem_write_activate (mem_write_activate),
    .mem_write_addr     (mem_write_addr),
    .mem_write_data     (mem_write_data),
    .mem_bytes_to_write (mem_bytes_to_write),
    .mem_write_done     (mem_write_done)
  );

  // Slow memory: write_done on every 16th cycle that activate is held.
  always @(negedge clk) begin
    if (mem_auto_en && mem_write_activate) begin
      act_run = act_run + 1;
      mem_done_auto = (act_run % 16 == 0);
    end else begin
      act_run = 0;
      mem_done_auto = 1'b0;
    end
  end

  // Memory side: a write commits at the edge following write_done.
  always @(posedge clk) begin
    if (mem_write_done && mem_write_activate) begin
      ce.addr  = mem_write_addr;
      ce.data  = mem_write_data;
      ce.bytes = mem_bytes_to_write;
      commit_q.push_back(ce);
      for (int k = 0; k < int'(ce.bytes); k++) begin
        mem_bytes[{32'd0, ce.addr} + 64'(k)] = ce.data[8*k +: 8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic void model_push(logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] b);
    ent_t e;
    e.addr  = a;
    e.data  = d;
    e.bytes = (b > 3'd4) ? 3'd4 : b;
    if (b != 3'd0) exp_q.push_back(e);
  endfunction

  // Byte-by-byte membership test over the stores the memory has not yet committed.
  function automatic logic model_hazard(logic [AW-1:0] la, logic [BW-1:0] lb);
    for (int i = commit_q.size(); i < exp_q.size(); i++) begin
      longint unsigned lo = {32'd0, exp_q[i].addr};
      longint unsigned hi = lo + 64'(exp_q[i].bytes);
      for (int k = 0; k < int'(lb); k++) begin
        longint unsigned b = {32'd0, la} + 64'(k);
        if (b >= lo && b < hi) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b,
                      input int budget, output bit ok);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_bytes = b;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = st_ready;
      @(posedge clk);
      #1;
    end
    st_valid = 1'b0;
    if (ok) model_push(a, d, b);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (empty) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ld_addr = 32'h0;
    ld_bytes = 3'd4;
    tick();
    tick();
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL rst_st_ready got=%b exp=0", st_ready); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (mem_write_activate !== 1'b0) begin failures++; $display("FAIL rst_activate got=%b exp=0", mem_write_activate); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rst_flush_done got=%b exp=0", flush_done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL post_rst_st_ready got=%b exp=1", st_ready); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL post_rst_empty got=%b exp=1", empty); end
    checks++; if (mem_write_activate !== 1'b0) begin failures++; $display("FAIL post_rst_activate got=%b exp=0", mem_write_activate); end
    checks++; if (mem_write_addr !== 32'h0 || mem_write_data !== 32'h0 || mem_bytes_to_write !== 3'd0) begin
      failures++; $display("FAIL post_rst_head got=%h/%h/%0d exp=0/0/0", mem_write_addr, mem_write_data, mem_bytes_to_write);
    end
    checks++; if (ld_hazard !== 1'b0) begin failures++; $display("FAIL post_rst_hazard got=%b exp=0", ld_hazard); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] expb [4];
    logic [7:0] got;
    int base;
    expb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    mem_auto_en = 1'b1;
    base = commit_q.size();
    push(32'h100, 32'hDEADBEEF, 3'd4, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_accept got=0 exp=1"); end
    @(negedge clk);
    checks++; if (mem_write_activate !== 1'b1) begin failures++; $display("FAIL single_activate got=%b exp=1", mem_write_activate); end
    checks++; if (mem_write_addr !== 32'h100 || mem_write_data !== 32'hDEADBEEF || mem_bytes_to_write !== 3'd4) begin
      failures++; $display("FAIL single_head got=%h/%h/%0d exp=100/deadbeef/4", mem_write_addr, mem_write_data, mem_bytes_to_write);
    end
    @(posedge clk);
    #1;
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain_timeout got=0 exp=1"); end
    for (int k = 0; k < 4; k++) begin
      got = mem_bytes.exists(64'h100 + 64'(k)) ? mem_bytes[64'h100 + 64'(k)] : 8'hxx;
      checks++; if (got !== expb[k]) begin failures++; $display("FAIL single_mem_byte%0d got=%h exp=%h", k, got, expb[k]); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
    checks++; if (commit_q.size() != base + 1) begin failures++; $display("FAIL single_commits got=%0d exp=%0d", commit_q.size(), base + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    logic [DW-1:0] d5;
    mem_auto_en = 1'b0;
    mem_done_force = 1'b0;
    base = commit_q.size();
    for (int i = 0; i < 4; i++) begin
      push(32'h400 + 32'(16 * i), $urandom, 3'($urandom_range(1, 7)), 1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_accept%0d got=0 exp=1", i); end
    end
    d5 = $urandom;
    st_valid = 1'b1; st_addr = 32'h440; st_data = d5; st_bytes = 3'd4;
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", st_ready); end
    @(posedge clk);
    #1;
    mem_done_force = 1'b1;
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL b2b_no_bypass got=%b exp=0", st_ready); end
    checks++; if (mem_write_addr !== exp_q[base].addr) begin failures++; $display("FAIL b2b_head got=%h exp=%h", mem_write_addr, exp_q[base].addr); end
    @(posedge clk);
    #1;
    mem_done_force = 1'b0;
    @(negedge clk);
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL b2b_after_pop_ready got=%b exp=1", st_ready); end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    model_push(32'h440, d5, 3'd4);
    mem_auto_en = 1'b1;
    wait_drain(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_drain_timeout got=0 exp=1"); end
    checks++; if (commit_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", commit_q.size(), exp_q.size()); end
    for (int i = base; i < commit_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (commit_q[i].addr !== exp_q[i].addr || commit_q[i].data !== exp_q[i].data || commit_q[i].bytes !== exp_q[i].bytes) begin
        failures++; $display("FAIL b2b_order%0d got=%h/%h/%0d exp=%h/%h/%0d", i, commit_q[i].addr, commit_q[i].data,
                             commit_q[i].bytes, exp_q[i].addr, exp_q[i].data, exp_q[i].bytes);
      end
    end
  endtask

  task automatic test_hazard();
    bit ok;
    logic [AW-1:0] la [8];
    logic [BW-1:0] lb [8];
    logic          le [8];
    logic          exp_h;
    la = '{32'h201, 32'h202, 32'h1FF, 32'h200, 32'h1FF, 32'h201, 32'h0, 32'hFFFFFFFF};
    lb = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd2, 3'd4, 3'd1, 3'd1};
    le = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    mem_auto_en = 1'b0;
    push(32'h200, $urandom, 3'd2, 1, ok);
    push(32'hFFFFFFFE, $urandom, 3'd4, 1, ok);
    for (int i = 0; i < 8; i++) begin
      ld_addr = la[i];
      ld_bytes = lb[i];
      @(negedge clk);
      checks++; if (ld_hazard !== le[i]) begin failures++; $display("FAIL hazard_fixed%0d got=%b exp=%b", i, ld_hazard, le[i]); end
      @(posedge clk);
      #1;
    end
    push(32'h200 + 32'($urandom_range(0, 15)), $urandom, 3'($urandom_range(1, 4)), 1, ok);
    push(32'h200 + 32'($urandom_range(0, 15)), $urandom, 3'($urandom_range(1, 4)), 1, ok);
    for (int i = 0; i < 24; i++) begin
      ld_addr = 32'h1F8 + 32'($urandom_range(0, 24));
      ld_bytes = 3'($urandom_range(0, 4));
      @(negedge clk);
      exp_h = model_hazard(ld_addr, ld_bytes);
      checks++; if (ld_hazard !== exp_h) begin failures++; $display("FAIL hazard_rand ld=%h/%0d got=%b exp=%b", ld_addr, ld_bytes, ld_hazard, exp_h); end
      @(posedge clk);
      #1;
    end
    mem_auto_en = 1'b1;
    wait_drain(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hazard_drain_timeout got=0 exp=1"); end
  endtask

  task automatic test_wrap();
    bit ok;
    bit rdy;
    int base;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    mem_auto_en = 1'b0;
    base = commit_q.size();
    push(32'h500, $urandom, 3'd4, 1, ok);
    push(32'h504, $urandom, 3'd4, 1, ok);
    for (int r = 0; r < 6; r++) begin
      a = 32'h510 + 32'(4 * r); d = $urandom; b = 3'($urandom_range(1, 4));
      st_valid = 1'b1; st_addr = a; st_data = d; st_bytes = b;
      mem_done_force = 1'b1;
      @(negedge clk);
      rdy = st_ready;
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL wrap_ready%0d got=%b exp=1", r, rdy); end
      checks++; if (mem_write_activate !== 1'b1 || mem_write_addr !== exp_q[commit_q.size()].addr ||
                    mem_write_data !== exp_q[commit_q.size()].data) begin
        failures++; $display("FAIL wrap_head%0d got=%h/%h exp=%h/%h", r, mem_write_addr, mem_write_data,
                             exp_q[commit_q.size()].addr, exp_q[commit_q.size()].data);
      end
      @(posedge clk);
      #1;
      if (rdy) model_push(a, d, b);
    end
    st_valid = 1'b0;
    mem_done_force = 1'b0;
    // Two slots must remain free if the simultaneous push/pop kept the count at 2.
    push(32'h540, $urandom, 3'd2, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_fill3 got=0 exp=1"); end
    push(32'h544, $urandom, 3'd2, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_fill4 got=0 exp=1"); end
    st_valid = 1'b1; st_addr = 32'h548; st_bytes = 3'd1;
    @(negedge clk);
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL wrap_full got=%b exp=0", st_ready); end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    mem_auto_en = 1'b1;
    wait_drain(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain_timeout got=0 exp=1"); end
    checks++; if (commit_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", commit_q.size(), exp_q.size()); end
    for (int i = base; i < commit_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (commit_q[i].addr !== exp_q[i].addr || commit_q[i].data !== exp_q[i].data || commit_q[i].bytes !== exp_q[i].bytes) begin
        failures++; $display("FAIL wrap_order%0d got=%h/%h/%0d exp=%h/%h/%0d", i, commit_q[i].addr, commit_q[i].data,
                             commit_q[i].bytes, exp_q[i].addr, exp_q[i].data, exp_q[i].bytes);
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    int bad;
    logic empty_at;
    mem_auto_en = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(8 * i), $urandom, 3'd4, 1, ok);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    bad = 0; seen = 1'b0; empty_at = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (st_ready !== 1'b0) bad++;
      if (flush_done === 1'b1) begin seen = 1'b1; empty_at = empty; end
      @(posedge clk);
      #1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL flush_done_seen got=0 exp=1"); end
    checks++; if (bad != 0) begin failures++; $display("FAIL flush_ready_low got=%0d exp=0", bad); end
    checks++; if (empty_at !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty_at); end
    @(negedge clk);
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_pulse_width got=%b exp=0", flush_done); end
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%b exp=1", st_ready); end
    checks++; if (commit_q.size() != exp_q.size()) begin failures++; $display("FAIL flush_commits got=%0d exp=%0d", commit_q.size(), exp_q.size()); end
    @(posedge clk);
    #1;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    checks++; if (flush_done !== 1'b1 || st_ready !== 1'b0) begin failures++; $display("FAIL flush_empty_pulse got=%b/%b exp=1/0", flush_done, st_ready); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (flush_done !== 1'b0 || st_ready !== 1'b1) begin failures++; $display("FAIL flush_empty_return got=%b/%b exp=0/1", flush_done, st_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    mem_auto_en = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h800 + 32'(4 * i), $urandom, 3'd4, 1, ok);
    n = commit_q.size();
    ld_addr = 32'h800; ld_bytes = 3'd1;
    rst = 1'b1;
    mem_done_force = 1'b1;
    @(negedge clk);
    checks++; if (mem_write_activate !== 1'b0) begin failures++; $display("FAIL midrst_activate got=%b exp=0", mem_write_activate); end
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", st_ready); end
    checks++; if (ld_hazard !== 1'b0) begin failures++; $display("FAIL midrst_hazard got=%b exp=0", ld_hazard); end
    @(posedge clk);
    #1;
    tick();
    checks++; if (commit_q.size() != n) begin failures++; $display("FAIL midrst_no_commit got=%0d exp=%0d", commit_q.size(), n); end
    rst = 1'b0;
    mem_done_force = 1'b0;
    exp_q.delete();
    commit_q.delete();
    @(negedge clk);
    checks++; if (empty !== 1'b1 || mem_write_activate !== 1'b0) begin failures++; $display("FAIL midrst_after got=%b/%b exp=1/0", empty, mem_write_activate); end
    checks++; if (mem_write_addr !== 32'h0 || mem_write_data !== 32'h0 || mem_bytes_to_write !== 3'd0) begin
      failures++; $display("FAIL midrst_head got=%h/%h/%0d exp=0/0/0", mem_write_addr, mem_write_data, mem_bytes_to_write);
    end
    checks++; if (ld_hazard !== 1'b0) begin failures++; $display("FAIL midrst_hazard_after got=%b exp=0", ld_hazard); end
    @(posedge clk);
    #1;
    push(32'h600, $urandom, 3'd0, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_byte_accept got=0 exp=1"); end
    @(negedge clk);
    checks++; if (empty !== 1'b1 || mem_write_activate !== 1'b0) begin failures++; $display("FAIL zero_byte_empty got=%b/%b exp=1/0", empty, mem_write_activate); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit ok;
    bit rdy;
    int pend;
    logic exp_h;
    mem_auto_en = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      st_valid = ($urandom_range(0, 2) == 0);
      st_addr  = 32'h300 + 32'($urandom_range(0, 31));
      st_data  = $urandom;
      st_bytes = 3'($urandom_range(0, 7));
      ld_addr  = 32'h2FC + 32'($urandom_range(0, 40));
      ld_bytes = 3'($urandom_range(0, 4));
      @(negedge clk);
      pend  = exp_q.size() - commit_q.size();
      exp_h = model_hazard(ld_addr, ld_bytes);
      rdy   = st_ready;
      checks++; if (ld_hazard !== exp_h) begin failures++; $display("FAIL rand_hazard cyc=%0d got=%b exp=%b", cyc, ld_hazard, exp_h); end
      checks++; if (rdy !== (pend != DEPTH)) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, rdy, pend != DEPTH); end
      checks++; if (empty !== (pend == 0)) begin failures++; $display("FAIL rand_empty cyc=%0d got=%b exp=%b", cyc, empty, pend == 0); end
      @(posedge clk);
      #1;
      if (st_valid && rdy) model_push(st_addr, st_data, st_bytes);
    end
    st_valid = 1'b0;
    wait_drain(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_drain_timeout got=0 exp=1"); end
    checks++; if (commit_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", commit_q.size(), exp_q.size()); end
    for (int i = 0; i < commit_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (commit_q[i].addr !== exp_q[i].addr || commit_q[i].data !== exp_q[i].data || commit_q[i].bytes !== exp_q[i].bytes) begin
        failures++; $display("FAIL rand_order%0d got=%h/%h/%0d exp=%h/%h/%0d", i, commit_q[i].addr, commit_q[i].data,
                             commit_q[i].bytes, exp_q[i].addr, exp_q[i].data, exp_q[i].bytes);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hazard();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
